spi_test_djuara: RTL and testbench

- SPI-slave (mode 0) controlled register block driving one 8-bit PWM output; a TinyTapeout user-project core.
- SPI pins enter on ui_in. MISO and PWM leave on uo_out.
- All logic runs on clk. SPI inputs are synchronised and edge-detected; no logic is clocked by SCLK.

---
 rtl/spi_test_pkg.sv | 19 +
 rtl/spi_slave_if.sv | 118 +++++++++++
 rtl/spi_test_djuara.sv | 100 ++++++++++
 tb/tb_spi_test_djuara.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/spi_test_pkg.sv
// Shared definitions for the SPI-controlled PWM block: register map, FSM states, ID value.
package spi_test_pkg;

  localparam logic [7:0] ID_VALUE = 8'hA5;

  localparam logic [6:0] ADDR_ID      = 7'h00;
  localparam logic [6:0] ADDR_CTRL    = 7'h01;
  localparam logic [6:0] ADDR_DUTY    = 7'h02;
  localparam logic [6:0] ADDR_PRESC   = 7'h03;
  localparam logic [6:0] ADDR_SCRATCH = 7'h04;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end: input synchronisers, SCLK edge detect, frame FSM and shift registers.
// wr_en is a one-cycle pulse with addr/wdata stable; rdata is sampled on the first SCLK fall of byte 1.
module spi_slave_if
  import spi_test_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs_n,
  input  logic [7:0] rdata,
  output logic       wr_en,
  output logic [6:0] addr,
  output logic [7:0] wdata,
  output logic       miso,
  output spi_state_t state
);

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, csn_sync;
  logic       sclk_s, mosi_s, csn_s;
  logic       sclk_q, csn_q;
  logic       sclk_rise, sclk_fall, csn_fall;
  spi_state_t state_next;
  logic [3:0] bit_cnt;
  logic [7:0] shift_in;
  logic [7:0] shift_out;
  logic       is_write;
  logic       loaded;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      csn_sync  <= '1;
      sclk_q    <= 1'b0;
      csn_q     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], cs_n};
      sclk_q    <= sclk_s;
      csn_q     <= csn_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign csn_s     = csn_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign csn_fall  = ~csn_s & csn_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (csn_s) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (csn_fall) state_next = ST_CMD;
        ST_CMD:  if (sclk_rise && bit_cnt == 4'd7) state_next = ST_DATA;
        ST_DATA: if (sclk_rise && bit_cnt == 4'd15) state_next = ST_DONE;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    miso = 1'b0;
    if (state == ST_DATA && !is_write && loaded && !csn_s) miso = shift_out[7];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift_in  <= '0;
      shift_out <= '0;
      is_write  <= 1'b0;
      loaded    <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      wr_en     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (state == ST_IDLE) begin
        bit_cnt   <= '0;
        shift_out <= '0;
        loaded    <= 1'b0;
      end else if ((state == ST_CMD || state == ST_DATA) && sclk_rise) begin
        shift_in <= {shift_in[6:0], mosi_s};
        bit_cnt  <= bit_cnt + 4'd1;
        if (state == ST_CMD && bit_cnt == 4'd7) begin
          is_write <= shift_in[6];
          addr     <= {shift_in[5:0], mosi_s};
        end
        // A deasserted CS_N on the final rise means the frame was aborted.
        if (state == ST_DATA && bit_cnt == 4'd15 && is_write && !csn_s) begin
          wr_en <= 1'b1;
          wdata <= {shift_in[6:0], mosi_s};
        end
      end else if (state == ST_DATA && sclk_fall && !is_write) begin
        if (!loaded) begin
          shift_out <= rdata;
          loaded    <= 1'b1;
        end else begin
          shift_out <= {shift_out[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/spi_test_djuara.sv
// TinyTapeout core: SPI-slave register block (ID/CTRL/DUTY/PRESC/SCRATCH) driving one 8-bit PWM output.
module spi_test_djuara #(
  parameter logic [7:0] ID_VALUE    = 8'hA5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  import spi_test_pkg::*;

  logic       wr_en;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       miso;
  spi_state_t spi_state;

  logic       ctrl_en;
  logic [7:0] duty, presc, scratch;
  logic [7:0] presc_cnt, pwm_cnt;
  logic       pwm;
  logic       unused_ok;

  spi_slave_if #(.SYNC_STAGES(SYNC_STAGES)) u_spi (
    .clk   (clk),
    .rst   (rst),
    .sclk  (ui_in[0]),
    .mosi  (ui_in[1]),
    .cs_n  (ui_in[2]),
    .rdata (rdata),
    .wr_en (wr_en),
    .addr  (addr),
    .wdata (wdata),
    .miso  (miso),
    .state (spi_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en <= 1'b0;
      duty    <= '0;
      presc   <= '0;
      scratch <= '0;
    end else if (wr_en) begin
      case (addr)
        ADDR_CTRL:    ctrl_en <= wdata[0];
        ADDR_DUTY:    duty    <= wdata;
        ADDR_PRESC:   presc   <= wdata;
        ADDR_SCRATCH: scratch <= wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (addr)
      ADDR_ID:      rdata = ID_VALUE;
      ADDR_CTRL:    rdata = {7'b0, ctrl_en};
      ADDR_DUTY:    rdata = duty;
      ADDR_PRESC:   rdata = presc;
      ADDR_SCRATCH: rdata = scratch;
      default:      rdata = 8'h00;
    endcase
  end

  // '>=' keeps the prescaler sane if PRESC is lowered below the running count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      pwm       <= 1'b0;
    end else if (!ctrl_en) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
      pwm       <= 1'b0;
    end else begin
      if (presc_cnt >= presc) begin
        presc_cnt <= '0;
        pwm_cnt   <= pwm_cnt + 8'd1;
      end else begin
        presc_cnt <= presc_cnt + 8'd1;
      end
      pwm <= (pwm_cnt < duty);
    end
  end

  assign uo_out  = {6'b0, pwm, miso};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:3], spi_state};

endmodule

// File: tb/tb_spi_test_djuara.sv
// Directed bench for spi_test_djuara: SPI frames from a task-based master, scoreboard on read data and PWM counts.
module tb_spi_test_djuara;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       sclk, mosi, csn;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  assign ui_in = {5'b0, csn, mosi, sclk};

  spi_test_djuara dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: expected values queued at stimulus time, compared when an observation is presented.
  logic [15:0] exp_q[$];
  logic [15:0] exp_head;
  int          n_vec = 0;
  int          n_err = 0;
  logic        obs_valid = 1'b0;
  logic [15:0] obs_data;
  string       obs_name;

  always @(posedge clk) begin
    if (obs_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL %s: got %h, no expected value queued", obs_name, obs_data);
      end else begin
        exp_head = exp_q.pop_front();
        if (obs_data !== exp_head) begin
          n_err++;
          $display("FAIL %s: got %h, expected %h", obs_name, obs_data, exp_head);
        end
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic present(input string name, input logic [15:0] act);
    obs_name  = name;
    obs_data  = act;
    obs_valid = 1'b1;
    @(negedge clk);
    obs_valid = 1'b0;
  endtask

  task automatic spi_xfer(input logic [7:0] b0, input logic [7:0] b1, input int nbits,
                          output logic [7:0] rd);
    logic [15:0] f;
    f   = {b0, b1};
    rd  = 8'h00;
    csn = 1'b0;
    clks(8);
    for (int i = 0; i < nbits; i++) begin
      mosi = f[15-i];
      clks(8);
      if (i >= 8) rd = {rd[6:0], uo_out[0]};
      sclk = 1'b1;
      clks(8);
      sclk = 1'b0;
    end
    clks(8);
    csn  = 1'b1;
    mosi = 1'b0;
    clks(8);
  endtask

  task automatic spi_write(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] dummy;
    spi_xfer({1'b1, a}, d, 16, dummy);
  endtask

  task automatic spi_read_check(input string name, input logic [6:0] a, input logic [7:0] exp);
    logic [7:0] rd;
    exp_q.push_back({8'h00, exp});
    spi_xfer({1'b0, a}, 8'h00, 16, rd);
    present(name, {8'h00, rd});
  endtask

  task automatic pwm_check(input string name, input int n, input int exp);
    int hi;
    hi = 0;
    exp_q.push_back(exp[15:0]);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uo_out[1]) hi++;
    end
    present(name, hi[15:0]);
  endtask

  initial begin
    rst    = 1'b1;
    ena    = 1'b1;
    csn    = 1'b1;
    sclk   = 1'b0;
    mosi   = 1'b0;
    uio_in = 8'h00;
    clks(4);
    exp_q.push_back(16'h0000); present("rst_uo_out", {8'h00, uo_out});
    exp_q.push_back(16'h0000); present("rst_uio_oe", {8'h00, uio_oe});
    exp_q.push_back(16'h0000); present("rst_uio_out", {8'h00, uio_out});
    rst = 1'b0;
    clks(4);

    spi_read_check("rst_ctrl_read", 7'h01, 8'h00);
    spi_read_check("id_read", 7'h00, 8'hA5);
    spi_write(7'h04, 8'h3C);
    spi_read_check("scratch_readback", 7'h04, 8'h3C);
    spi_write(7'h00, 8'hFF);
    spi_read_check("id_write_ignored", 7'h00, 8'hA5);
    spi_read_check("unmapped_read", 7'h10, 8'h00);

    begin
      logic [7:0] dummy;
      spi_xfer(8'h84, 8'h55, 12, dummy);
    end
    spi_read_check("abort_no_commit", 7'h04, 8'h3C);
    spi_write(7'h02, 8'h5A);
    spi_read_check("after_abort_frame", 7'h02, 8'h5A);

    spi_write(7'h03, 8'h00);
    spi_write(7'h02, 8'd64);
    spi_write(7'h01, 8'h01);
    spi_read_check("ctrl_readback", 7'h01, 8'h01);
    clks(20);
    pwm_check("pwm_duty64", 256, 64);
    spi_write(7'h02, 8'h00);
    clks(20);
    pwm_check("pwm_duty0", 256, 0);
    spi_write(7'h02, 8'd200);
    spi_write(7'h01, 8'h00);
    clks(20);
    pwm_check("pwm_ctrl_off", 256, 0);

    spi_write(7'h03, 8'h03);
    spi_write(7'h02, 8'd128);
    spi_write(7'h01, 8'h01);
    spi_read_check("presc_readback", 7'h03, 8'h03);
    clks(20);
    pwm_check("pwm_presc3", 1024, 512);

    // Reset in the middle of a write frame.
    csn = 1'b0;
    clks(8);
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b1;
      clks(8);
      sclk = 1'b1;
      clks(8);
      sclk = 1'b0;
    end
    rst = 1'b1;
    clks(2);
    exp_q.push_back(16'h0000); present("midframe_rst_uo_out", {8'h00, uo_out});
    csn  = 1'b1;
    mosi = 1'b0;
    clks(4);
    rst = 1'b0;
    clks(8);
    spi_read_check("rst_clr_ctrl", 7'h01, 8'h00);
    spi_read_check("rst_clr_duty", 7'h02, 8'h00);
    spi_read_check("rst_clr_presc", 7'h03, 8'h00);
    spi_read_check("rst_clr_scratch", 7'h04, 8'h00);
    pwm_check("pwm_after_rst", 256, 0);

    clks(4);
    if (exp_q.size() != 0) begin
      n_err += exp_q.size();
      $display("FAIL scoreboard_drain: %0d expected values left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
